// File: rtl/frame_fifo_pkg.sv
// Shared definitions for the frame FIFO reader and writer: FSM state
// encodings and single-bit strobe constants.
package frame_fifo_pkg;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE            = 3'd0,
    S_ACK             = 3'd1,
    S_CHECK_FIFO      = 3'd2,
    S_WRITE_BURST     = 3'd3,
    S_WRITE_BURST_END = 3'd4,
    S_END             = 3'd5
  } state_t;

endpackage

// File: rtl/frame_req_sync.sv
// Brings the asynchronous frame request and its qualifiers into the memory
// clock domain. The request gets one more stage than the buses, so length and
// index have settled by the time the request is seen.
module frame_req_sync #(
  parameter int ADDR_BITS = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [ADDR_BITS-1:0] len,
  input  logic [1:0]           index,
  output logic                 req_d2,
  output logic [ADDR_BITS-1:0] len_d1,
  output logic [1:0]           index_d1
);

  logic                 req_d0;
  logic                 req_d1;
  logic [ADDR_BITS-1:0] len_d0;
  logic [1:0]           index_d0;

  // Three-flop request chain and two-flop bus chains.
  // NOTE: flops use non-blocking assignments so every stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d0   <= 1'b0;
      req_d1   <= 1'b0;
      req_d2   <= 1'b0;
      len_d0   <= '0;
      len_d1   <= '0;
      index_d0 <= '0;
      index_d1 <= '0;
    end else begin
      req_d0   <= req;
      req_d1   <= req_d0;
      req_d2   <= req_d1;
      len_d0   <= len;
      len_d1   <= len_d0;
      index_d0 <= index;
      index_d1 <= index_d0;
    end
  end

endmodule

// File: rtl/frame_fifo_write.sv
// Frame writer: drains a frame of words from the line FIFO into SDRAM in
// bursts of up to BURST_SIZE words, starting at one of four base addresses.
module frame_fifo_write
  import frame_fifo_pkg::*;
#(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 21,
  parameter int BURST_BITS    = 9,
  parameter int FIFO_DEPTH    = 512,
  parameter int BURST_SIZE    = 128
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     Sdr_init_done,
  input  logic                     Sdr_busy,
  input  logic                     App_rd_busy,
  output logic                     O_wr_busy,
  output logic                     App_wr_en,
  output logic [ADDR_BITS-1:0]     App_wr_addr,
  output logic [MEM_DATA_BITS-1:0] App_wr_data,
  input  logic                     write_req,
  output logic                     write_req_ack,
  output logic                     write_finish,
  input  logic [ADDR_BITS-1:0]     write_addr_0,
  input  logic [ADDR_BITS-1:0]     write_addr_1,
  input  logic [ADDR_BITS-1:0]     write_addr_2,
  input  logic [ADDR_BITS-1:0]     write_addr_3,
  input  logic [1:0]               write_addr_index,
  input  logic [ADDR_BITS-1:0]     write_len,
  output logic                     fifo_aclr,
  output logic                     fifo_rd_en,
  input  logic [MEM_DATA_BITS-1:0] fifo_q,
  input  logic [9:0]               rdusedw
);

  // A burst never asks for more words than the FIFO can hold.
  localparam int                   BURST_CAP   = (BURST_SIZE < FIFO_DEPTH) ? BURST_SIZE : FIFO_DEPTH;
  localparam logic [ADDR_BITS-1:0] CAP_ADDR_W  = ADDR_BITS'(BURST_CAP);
  localparam logic [BURST_BITS-1:0] CAP_BURST_W = BURST_BITS'(BURST_CAP);

  state_t                 state;
  state_t                 state_next;
  logic                   req_d2;
  logic [ADDR_BITS-1:0]   len_sync;
  logic [1:0]             index_sync;
  logic [ADDR_BITS-1:0]   len_latch;
  logic [ADDR_BITS-1:0]   write_cnt;
  logic [ADDR_BITS-1:0]   remaining;
  logic [ADDR_BITS-1:0]   base_sel;
  logic [BURST_BITS-1:0]  burst_len;
  logic [BURST_BITS-1:0]  rd_cnt;
  logic                   fifo_ready;
  logic                   burst_done;

  frame_req_sync #(.ADDR_BITS(ADDR_BITS)) u_sync (
    .clk      (mem_clk),
    .rst      (rst),
    .req      (write_req),
    .len      (write_len),
    .index    (write_addr_index),
    .req_d2   (req_d2),
    .len_d1   (len_sync),
    .index_d1 (index_sync)
  );

  // Burst sizing, start condition and burst completion.
  always_comb begin
    remaining  = len_latch - write_cnt;
    burst_len  = (remaining >= CAP_ADDR_W) ? CAP_BURST_W : BURST_BITS'(remaining);
    fifo_ready = (32'(rdusedw) >= 32'(burst_len)) && !App_rd_busy && !Sdr_busy;
    fifo_rd_en = (state == S_WRITE_BURST) && (rd_cnt != burst_len);
    burst_done = (state == S_WRITE_BURST) && (rd_cnt == burst_len) && !App_wr_en;
    App_wr_data = App_wr_en ? fifo_q : '0;
  end

  // Base address selected by the synchronized index.
  always_comb begin
    unique case (index_sync)
      2'd0:    base_sel = write_addr_0;
      2'd1:    base_sel = write_addr_1;
      2'd2:    base_sel = write_addr_2;
      default: base_sel = write_addr_3;
    endcase
  end

  // State register.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next    = state;
    write_req_ack = ZERO;
    fifo_aclr     = ZERO;
    write_finish  = ZERO;
    O_wr_busy     = ZERO;
    case (state)
      S_IDLE: begin
        if (req_d2 && Sdr_init_done) state_next = S_ACK;
      end
      S_ACK: begin
        if (req_d2) begin
          write_req_ack = ONE;
          fifo_aclr     = ONE;
        end else begin
          state_next = S_CHECK_FIFO;
        end
      end
      S_CHECK_FIFO: begin
        if (req_d2)                 state_next = S_ACK;
        else if (burst_len == '0)   state_next = S_WRITE_BURST_END;
        else if (fifo_ready)        state_next = S_WRITE_BURST;
      end
      S_WRITE_BURST: begin
        O_wr_busy = ONE;
        if (burst_done) state_next = S_WRITE_BURST_END;
      end
      S_WRITE_BURST_END: begin
        if (req_d2)                     state_next = S_ACK;
        else if (write_cnt < len_latch) state_next = S_CHECK_FIFO;
        else                            state_next = S_END;
      end
      S_END: begin
        write_finish = ONE;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Write strobe, address, frame length and progress counters.
  // NOTE: every register here is cleared by the asynchronous reset so a
  // reset mid-burst kills the strobes on the same edge.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      App_wr_en   <= 1'b0;
      App_wr_addr <= '0;
      len_latch   <= '0;
      write_cnt   <= '0;
      rd_cnt      <= '0;
    end else begin
      App_wr_en <= fifo_rd_en;
      if (state == S_WRITE_BURST) begin
        if (fifo_rd_en) rd_cnt <= rd_cnt + BURST_BITS'(1);
      end else begin
        rd_cnt <= '0;
      end
      if (state == S_ACK && req_d2) begin
        len_latch   <= len_sync;
        App_wr_addr <= base_sel;
        write_cnt   <= '0;
      end else begin
        if (App_wr_en)  App_wr_addr <= App_wr_addr + ADDR_BITS'(1);
        if (burst_done) write_cnt   <= write_cnt + ADDR_BITS'(burst_len);
      end
    end
  end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Randomized self-checking bench for frame_fifo_write. A small FIFO model
// supplies data; expected bursts, addresses and data come from the frame rules.
module tb_frame_fifo_write;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int BURST = 128;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          Sdr_init_done = 1'b1;
  logic          Sdr_busy = 1'b0;
  logic          App_rd_busy = 1'b0;
  logic          O_wr_busy;
  logic          App_wr_en;
  logic [AW-1:0] App_wr_addr;
  logic [DW-1:0] App_wr_data;
  logic          write_req = 1'b0;
  logic          write_req_ack;
  logic          write_finish;
  logic [AW-1:0] bases [4];
  logic [1:0]    write_addr_index = 2'd0;
  logic [AW-1:0] write_len = '0;
  logic          fifo_aclr;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_q = '0;
  logic [9:0]    rdusedw = 10'd300;

  frame_fifo_write dut (
    .mem_clk          (mem_clk),
    .rst              (rst),
    .Sdr_init_done    (Sdr_init_done),
    .Sdr_busy         (Sdr_busy),
    .App_rd_busy      (App_rd_busy),
    .O_wr_busy        (O_wr_busy),
    .App_wr_en        (App_wr_en),
    .App_wr_addr      (App_wr_addr),
    .App_wr_data      (App_wr_data),
    .write_req        (write_req),
    .write_req_ack    (write_req_ack),
    .write_finish     (write_finish),
    .write_addr_0     (bases[0]),
    .write_addr_1     (bases[1]),
    .write_addr_2     (bases[2]),
    .write_addr_3     (bases[3]),
    .write_addr_index (write_addr_index),
    .write_len        (write_len),
    .fifo_aclr        (fifo_aclr),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_q           (fifo_q),
    .rdusedw          (rdusedw)
  );

  always #5 mem_clk = ~mem_clk;

  int total = 0;
  int bad = 0;

  // FIFO model: 1-cycle read latency, cleared by fifo_aclr.
  logic [DW-1:0] words [1024];
  int fptr = 0;
  always @(posedge mem_clk) begin
    if (fifo_aclr) fptr <= 0;
    else if (fifo_rd_en) begin
      fifo_q <= (fptr < 1024) ? words[fptr] : '0;
      fptr   <= fptr + 1;
    end
  end

  // Optional random controller-busy noise.
  logic rand_busy = 1'b0;
  always @(posedge mem_clk) begin
    #1;
    Sdr_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: records every write and burst run at the falling edge.
  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] data_q [$];
  int runs_q [$];
  int run_len = 0, finish_cnt = 0, aclr_cnt = 0, rden_cnt = 0;
  always @(negedge mem_clk) begin
    if (App_wr_en) begin
      addr_q.push_back(App_wr_addr);
      data_q.push_back(App_wr_data);
      run_len++;
    end else if (run_len != 0) begin
      runs_q.push_back(run_len);
      run_len = 0;
    end
    if (write_finish) finish_cnt++;
    if (fifo_aclr)    aclr_cnt++;
    if (fifo_rd_en)   rden_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic clear_mon();
    addr_q.delete(); data_q.delete(); runs_q.delete();
    run_len = 0; finish_cnt = 0; aclr_cnt = 0; rden_cnt = 0;
    for (int i = 0; i < 1024; i++) words[i] = $urandom;
  endtask

  task automatic start_req(input int idx, input int len);
    int n;
    write_addr_index = idx[1:0];
    write_len        = len[AW-1:0];
    write_req        = 1'b1;
    n = 0;
    while (!write_req_ack && n < 500) begin tick(); n++; end
    check("ack_seen", write_req_ack, 1);
    write_req = 1'b0;
  endtask

  task automatic wait_finish(input int limit);
    int n;
    n = 0;
    while (finish_cnt == 0 && n < limit) begin tick(); n++; end
    repeat (3) tick();
  endtask

  // Compares one recorded frame against the burst/address/data rules.
  task automatic check_frame(input string tag, input logic [AW-1:0] base, input int len);
    int exp_runs [$];
    int rem, run_bad, addr_bad, data_bad;
    logic [AW-1:0] ea;
    rem = len;
    while (rem > 0) begin
      exp_runs.push_back(rem > BURST ? BURST : rem);
      rem -= (rem > BURST ? BURST : rem);
    end
    check({tag, "_writes"}, addr_q.size(), len);
    check({tag, "_bursts"}, runs_q.size(), exp_runs.size());
    run_bad = 0;
    for (int i = 0; i < runs_q.size() && i < exp_runs.size(); i++)
      if (runs_q[i] != exp_runs[i]) run_bad++;
    check({tag, "_burst_len_err"}, run_bad, 0);
    addr_bad = 0; data_bad = 0;
    for (int i = 0; i < addr_q.size() && i < len; i++) begin
      ea = base + AW'(i);
      if (addr_q[i] !== ea) addr_bad++;
      if (data_q[i] !== words[i]) data_bad++;
    end
    check({tag, "_addr_err"}, addr_bad, 0);
    check({tag, "_data_err"}, data_bad, 0);
    check({tag, "_finish"}, finish_cnt, 1);
  endtask

  initial begin
    int snap;
    int n;
    bases[0] = AW'($urandom);
    bases[1] = 21'h001000;
    bases[2] = AW'($urandom);
    bases[3] = 21'h1FFFF0;
    clear_mon();
    repeat (3) tick();

    // Reset values.
    check("rst_ack", write_req_ack, 0);
    check("rst_finish", write_finish, 0);
    check("rst_aclr", fifo_aclr, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_wr_en", App_wr_en, 0);
    check("rst_busy", O_wr_busy, 0);
    check("rst_addr", App_wr_addr, 0);
    check("rst_data", App_wr_data, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Request ignored until SDRAM init completes.
    Sdr_init_done = 1'b0;
    write_req = 1'b1;
    n = 0;
    repeat (20) begin tick(); if (write_req_ack) n++; end
    check("no_ack_before_init", n, 0);
    write_req = 1'b0;
    repeat (6) tick();
    Sdr_init_done = 1'b1;
    clear_mon();

    // Two full bursts from base1.
    start_req(1, 256);
    check("aclr_during_ack", fifo_aclr, 1);
    wait_finish(2000);
    check_frame("len256", bases[1], 256);
    check("len256_last_addr", addr_q[255], 21'h0010FF);

    // Full burst followed by a short one.
    clear_mon();
    start_req(2, 200);
    wait_finish(2000);
    check_frame("len200", bases[2], 200);
    check("len200_last_addr", addr_q[199], bases[2] + 21'd199);

    // Zero-length frame: handshake and finish, no writes.
    clear_mon();
    start_req(0, 0);
    wait_finish(200);
    check_frame("len0", bases[0], 0);

    // Address wrap at the top of the address space.
    clear_mon();
    start_req(3, 40);
    wait_finish(1000);
    check_frame("wrap", bases[3], 40);

    // Not enough FIFO words: hold off until exactly one burst is available.
    clear_mon();
    rdusedw = 10'd100;
    start_req(0, 256);
    repeat (40) tick();
    check("low_fill_no_read", rden_cnt, 0);
    rdusedw = 10'd128;
    wait_finish(2000);
    check_frame("low_fill", bases[0], 256);
    rdusedw = 10'd300;

    // Reader busy blocks the start; release starts the burst next cycle.
    clear_mon();
    App_rd_busy = 1'b1;
    start_req(1, 128);
    repeat (20) tick();
    check("rd_busy_no_read", rden_cnt, 0);
    check("rd_busy_rd_en", fifo_rd_en, 0);
    App_rd_busy = 1'b0;
    tick();
    check("rd_busy_release_rd_en", fifo_rd_en, 1);
    check("rd_busy_release_busy", O_wr_busy, 1);
    wait_finish(1000);
    check_frame("rd_busy", bases[1], 128);

    // New request mid-burst: burst completes, then reload from the new base.
    clear_mon();
    start_req(0, 256);
    n = 0;
    while (addr_q.size() < 40 && n < 500) begin tick(); n++; end
    write_addr_index = 2'd2;
    write_len = 21'd64;
    write_req = 1'b1;
    n = 0;
    while (!write_req_ack && n < 500) begin tick(); n++; end
    check("mid_ack_seen", write_req_ack, 1);
    check("mid_writes_at_ack", addr_q.size(), 128);
    check("mid_aclr", fifo_aclr, 1);
    write_req = 1'b0;
    wait_finish(2000);
    check("mid_total", addr_q.size(), 192);
    check("mid_first_run", runs_q.size() > 0 ? runs_q[0] : 0, 128);
    check("mid_second_run", runs_q.size() > 1 ? runs_q[1] : 0, 64);
    check("mid_last_old_addr", addr_q.size() > 127 ? addr_q[127] : '0, bases[0] + 21'd127);
    check("mid_reload_addr", addr_q.size() > 128 ? addr_q[128] : '0, bases[2]);
    check("mid_reload_data", data_q.size() > 128 ? data_q[128] : '0, words[0]);
    check("mid_finish", finish_cnt, 1);

    // Random frames with controller-busy noise.
    rand_busy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int idx, len;
      bases[0] = AW'($urandom);
      bases[2] = AW'($urandom);
      idx = $urandom_range(0, 3);
      len = $urandom_range(1, 400);
      rdusedw = 10'($urandom_range(128, 1023));
      clear_mon();
      start_req(idx, len);
      wait_finish(4000);
      check_frame($sformatf("rand%0d", f), bases[idx], len);
    end
    rand_busy = 1'b0;
    rdusedw = 10'd300;
    repeat (3) tick();

    // Reset at word 50 kills strobes immediately; nothing resumes after.
    clear_mon();
    start_req(1, 256);
    n = 0;
    while (addr_q.size() < 50 && n < 500) begin tick(); n++; end
    rst = 1'b1;
    #1;
    snap = addr_q.size();
    check("rst_mid_wr_en", App_wr_en, 0);
    check("rst_mid_rd_en", fifo_rd_en, 0);
    check("rst_mid_busy", O_wr_busy, 0);
    check("rst_mid_addr", App_wr_addr, 0);
    check("rst_mid_data", App_wr_data, 0);
    check("rst_mid_ack", write_req_ack, 0);
    check("rst_mid_aclr", fifo_aclr, 0);
    check("rst_mid_finish", write_finish, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    check("post_rst_no_writes", addr_q.size(), snap);
    check("post_rst_no_finish", finish_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
